// File: rtl/qpmm_op_sequencer.sv
// qpmm_op_sequencer
// Takes multiply commands from a small queue and feeds the pipelined Montgomery
// multiplier one operation per cycle. Operand A comes from bank 0 and operand B
// from bank 1. Each product is written back to its destination in both banks.
// The head command waits while any in-flight product targets one of its sources.

module qpmm_op_sequencer #(
  parameter int DW         = 272,
  parameter int AW         = 8,
  parameter int RAM_RD_LAT = 2,
  parameter int MUL_LAT    = 30,
  parameter int CQ_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_src_a,
  input  logic [AW-1:0] cmd_src_b,
  input  logic [AW-1:0] cmd_dst,
  output logic [AW-1:0] ram0_addrb,
  output logic [AW-1:0] ram1_addrb,
  input  logic [DW-1:0] ram0_doutb,
  input  logic [DW-1:0] ram1_doutb,
  output logic [DW-1:0] mul_A,
  output logic [DW-1:0] mul_B,
  input  logic [DW-1:0] mul_Z,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  output logic          ram_wea,
  output logic          idle,
  output logic [15:0]   retire_cnt
);

  // Stage k of the in-flight pipe is valid k+1 cycles after the issue cycle.
  // The capture stage lines up with valid read data, and the last stage lines
  // up with the product leaving the multiplier.
  localparam int NST = RAM_RD_LAT + 1 + MUL_LAT;
  localparam int CAP = RAM_RD_LAT - 1;
  localparam int PW  = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(CQ_DEPTH);

  logic [AW-1:0] r_qSrcA [CQ_DEPTH];
  logic [AW-1:0] r_qSrcB [CQ_DEPTH];
  logic [AW-1:0] r_qDst  [CQ_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;
  logic          r_cmdReady;

  logic [AW-1:0] r_ram0Addr;
  logic [AW-1:0] r_ram1Addr;
  logic [NST-1:0] r_vld;
  logic [AW-1:0] r_dst [NST];
  logic [DW-1:0] r_mulA;
  logic [DW-1:0] r_mulB;
  logic [15:0]   r_retireCnt;

  logic          w_push;
  logic          w_issue;
  logic          w_hazard;
  logic [PW:0]   w_countNext;
  logic [AW-1:0] w_headA;
  logic [AW-1:0] w_headB;
  logic [AW-1:0] w_headDst;

  assign w_push    = cmd_valid && r_cmdReady;
  assign w_headA   = r_qSrcA[r_rdPtr];
  assign w_headB   = r_qSrcB[r_rdPtr];
  assign w_headDst = r_qDst[r_rdPtr];
  assign w_issue   = (r_count != '0) && !w_hazard;

  // Block the head while any in-flight product, including the one being written now, targets one of its sources.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < NST; i++) begin
      if (r_vld[i] && ((r_dst[i] == w_headA) || (r_dst[i] == w_headB))) begin
        w_hazard = 1'b1;
      end
    end
  end

  // Queue occupancy for the coming cycle; a push into an empty queue is not bypassed.
  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_issue) begin
      w_countNext = r_count + 1'b1;
    end else if (!w_push && w_issue) begin
      w_countNext = r_count - 1'b1;
    end
  end

  // Command storage holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qSrcA[r_wrPtr] <= cmd_src_a;
      r_qSrcB[r_wrPtr] <= cmd_src_b;
      r_qDst[r_wrPtr]  <= cmd_dst;
    end
  end

  // Queue pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_cmdReady <= 1'b1;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_issue) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count    <= w_countNext;
      r_cmdReady <= (w_countNext != FULL_CNT);
    end
  end

  // Issue drives the read addresses and shifts a valid bit and the destination into the in-flight pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram0Addr <= '0;
      r_ram1Addr <= '0;
      r_vld      <= '0;
      for (int i = 0; i < NST; i++) begin
        r_dst[i] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_ram0Addr <= w_headA;
        r_ram1Addr <= w_headB;
      end
      r_vld    <= {r_vld[NST-2:0], w_issue};
      r_dst[0] <= w_headDst;
      for (int i = 1; i < NST; i++) begin
        r_dst[i] <= r_dst[i-1];
      end
    end
  end

  // Capture read data into the multiplier input registers when it becomes valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mulA <= '0;
      r_mulB <= '0;
    end else if (r_vld[CAP]) begin
      r_mulA <= ram0_doutb;
      r_mulB <= ram1_doutb;
    end
  end

  // Count each completed write; the counter wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retireCnt <= '0;
    end else if (r_vld[NST-1]) begin
      r_retireCnt <= r_retireCnt + 16'd1;
    end
  end

  // The write port is driven straight from the last pipe stage.
  // The address and data are zeroed when no write is active.
  assign ram_wea    = r_vld[NST-1];
  assign ram_addra  = r_vld[NST-1] ? r_dst[NST-1] : '0;
  assign ram_dina   = r_vld[NST-1] ? mul_Z : '0;

  assign cmd_ready  = r_cmdReady;
  assign ram0_addrb = r_ram0Addr;
  assign ram1_addrb = r_ram1Addr;
  assign mul_A      = r_mulA;
  assign mul_B      = r_mulB;
  assign retire_cnt = r_retireCnt;
  assign idle       = (r_count == '0) && (r_vld == '0);

endmodule
